// File: rtl/lpc_fixed_decoder.sv
// lpc_fixed_decoder
//   Rebuilds PCM samples from fixed-predictor (order 0..4) LPC residuals.
//   Each output feeds back into the next prediction, so the whole
//   predict + add + history update happens in one cycle behind a registered
//   output.
//
// Ports:
//   iClock      : clock, rising edge
//   iReset_n    : synchronous active-low reset
//   iEnable     : iResidual valid and consumed this cycle
//   iFrameStart : (with iEnable) first word of a new subframe
//   iOrder      : predictor order, latched on frame start (5..7 -> 4)
//   iResidual   : residual word, or raw sample during warmup
//   oSample     : reconstructed sample (holds when iEnable=0)
//   oValid      : registered iEnable
//   oWarmup     : oSample is a verbatim warmup sample
module lpc_fixed_decoder #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = SAMPLE_W + 5
) (
  input  logic                iClock,
  input  logic                iReset_n,
  input  logic                iEnable,
  input  logic                iFrameStart,
  input  logic [2:0]          iOrder,
  input  logic [SAMPLE_W-1:0] iResidual,
  output logic [SAMPLE_W-1:0] oSample,
  output logic                oValid,
  output logic                oWarmup
);

  typedef enum logic [2:0] {
    ORD0 = 3'd0,
    ORD1 = 3'd1,
    ORD2 = 3'd2,
    ORD3 = 3'd3,
    ORD4 = 3'd4
  } order_t;

  typedef logic signed [ACC_W-1:0] acc_t;

  order_t              ord_q;
  logic [2:0]          warm_cnt_q;
  logic [SAMPLE_W-1:0] s1_q, s2_q, s3_q, s4_q;

  order_t              ord_eff;
  logic [2:0]          warm_cnt_eff;
  logic                is_warm;
  acc_t                a1, a2, a3, a4, ar;
  acc_t                pred;
  logic [SAMPLE_W-1:0] x_new;

  function automatic acc_t sx(input logic [SAMPLE_W-1:0] v);
    return acc_t'($signed(v));
  endfunction

  function automatic order_t clamp_order(input logic [2:0] o);
    return (o > 3'd4) ? ORD4 : order_t'(o);
  endfunction

  // A frame-start word uses the new order immediately, so both the order and
  // the warmup count are muxed ahead of the datapath rather than taken from
  // the registers.
  always_comb begin
    ord_eff      = ord_q;
    warm_cnt_eff = warm_cnt_q;
    if (iFrameStart) begin
      ord_eff      = clamp_order(iOrder);
      warm_cnt_eff = clamp_order(iOrder);
    end
    is_warm = (warm_cnt_eff != 3'd0);
  end

  // Fixed predictors with constant multiplies as shift-adds.
  always_comb begin
    a1   = sx(s1_q);
    a2   = sx(s2_q);
    a3   = sx(s3_q);
    a4   = sx(s4_q);
    ar   = sx(iResidual);
    pred = '0;
    unique case (ord_eff)
      ORD1:    pred = a1;
      ORD2:    pred = (a1 <<< 1) - a2;
      ORD3:    pred = ((a1 <<< 1) + a1) - ((a2 <<< 1) + a2) + a3;
      ORD4:    pred = (a1 <<< 2) - ((a2 <<< 2) + (a2 <<< 1)) + (a3 <<< 2) - a4;
      default: pred = '0;
    endcase
    // Truncation gives two's-complement wrap; the wrapped value is also what
    // enters the history, matching the encoder's arithmetic modulo 2^SAMPLE_W.
    x_new = is_warm ? iResidual : SAMPLE_W'(pred + ar);
  end

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      ord_q      <= ORD0;
      warm_cnt_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      s4_q       <= '0;
      oSample    <= '0;
      oValid     <= 1'b0;
      oWarmup    <= 1'b0;
    end else begin
      oValid <= iEnable;
      if (iEnable) begin
        ord_q      <= ord_eff;
        warm_cnt_q <= is_warm ? warm_cnt_eff - 3'd1 : 3'd0;
        s4_q       <= s3_q;
        s3_q       <= s2_q;
        s2_q       <= s1_q;
        s1_q       <= x_new;
        oSample    <= x_new;
        oWarmup    <= is_warm;
      end
    end
  end

endmodule

// File: tb/tb_lpc_fixed_decoder.sv
// Self-checking bench for lpc_fixed_decoder: directed vectors plus a
// randomized order-4 encode/decode roundtrip with a mid-stream reset.
module tb_lpc_fixed_decoder;

  logic        iClock = 1'b0;
  logic        iReset_n;
  logic        iEnable;
  logic        iFrameStart;
  logic [2:0]  iOrder;
  logic [15:0] iResidual;
  logic [15:0] oSample;
  logic        oValid;
  logic        oWarmup;

  lpc_fixed_decoder #(.SAMPLE_W(16), .ACC_W(21)) dut (
    .iClock      (iClock),
    .iReset_n    (iReset_n),
    .iEnable     (iEnable),
    .iFrameStart (iFrameStart),
    .iOrder      (iOrder),
    .iResidual   (iResidual),
    .oSample     (oSample),
    .oValid      (oValid),
    .oWarmup     (oWarmup)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic [15:0] s;
    logic        w;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] last_s;
  logic        last_w;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle; expected output is queued when a word is consumed and
  // popped when the DUT flags it valid one edge later.
  task automatic send(input logic en, input logic fs, input logic [2:0] ord,
                      input logic [15:0] res, input logic [15:0] es, input logic ew);
    exp_t e;
    iEnable     = en;
    iFrameStart = fs;
    iOrder      = ord;
    iResidual   = res;
    if (en) sb.push_back('{s: es, w: ew});
    @(posedge iClock);
    #1;
    check("valid", 32'(oValid), 32'(en));
    if (oValid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(oValid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sample", 32'(oSample), 32'(e.s));
        check("warmup", 32'(oWarmup), 32'(e.w));
        last_s = e.s;
        last_w = e.w;
      end
    end else begin
      check("hold_sample", 32'(oSample), 32'(last_s));
      check("hold_warmup", 32'(oWarmup), 32'(last_w));
    end
  endtask

  task automatic do_reset(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      iReset_n    = 1'b0;
      iEnable     = 1'b1;
      iFrameStart = 1'b0;
      iOrder      = 3'd4;
      iResidual   = 16'h1234;
      @(posedge iClock);
      #1;
      check("rst_sample", 32'(oSample), 32'd0);
      check("rst_valid", 32'(oValid), 32'd0);
      check("rst_warmup", 32'(oWarmup), 32'd0);
    end
    iReset_n = 1'b1;
    iEnable  = 1'b0;
    sb.delete();
    last_s = '0;
    last_w = 1'b0;
  endtask

  // Encoder side of the roundtrip: raw warmup words then order-4 residuals.
  task automatic roundtrip(input logic [2:0] ord_in, input int unsigned n);
    int          h1 = 0, h2 = 0, h3 = 0, h4 = 0;
    int          xi, p;
    logic [15:0] x, res;
    for (int unsigned k = 0; k < n; k++) begin
      if ($urandom_range(0, 9) == 0)
        send(1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom), 16'h0, 1'b0);
      x  = 16'($urandom);
      xi = int'($signed(x));
      p  = 4 * h1 - 6 * h2 + 4 * h3 - h4;
      res = (k < 4) ? x : 16'(xi - p);
      send(1'b1, (k == 0), (k == 0) ? ord_in : 3'($urandom), res, x, (k < 4));
      h4 = h3; h3 = h2; h2 = h1; h1 = xi;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset_n = 1'b0; iEnable = 1'b0; iFrameStart = 1'b0; iOrder = '0; iResidual = '0;
    last_s = '0; last_w = 1'b0;
    do_reset(2);

    // Before any frame start, order is 0: pass-through.
    send(1'b1, 1'b0, 3'd4, 16'h0055, 16'h0055, 1'b0);

    // Order 4 ramp.
    send(1'b1, 1'b1, 3'd4, 16'd1, 16'd1, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd2, 16'd2, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd3, 16'd3, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd4, 16'd4, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'd5, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'd6, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'd7, 1'b0);

    // Order 2 with residuals.
    send(1'b1, 1'b1, 3'd2, 16'd10, 16'd10, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd20, 16'd20, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd0,  16'd30, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd5,  16'd45, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'hFFFD, 16'd57, 1'b0);

    // Wrap at the positive limit.
    send(1'b1, 1'b1, 3'd1, 16'h7FFF, 16'h7FFF, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd1, 16'h8000, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'h8000, 1'b0);

    // Order 3 with enable gaps; a frame start without enable must be ignored.
    send(1'b1, 1'b1, 3'd3, 16'd1, 16'd1, 1'b1);
    send(1'b0, 1'b1, 3'd0, 16'd99, 16'd0, 1'b0);
    send(1'b0, 1'b1, 3'd0, 16'd99, 16'd0, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd4, 16'd4, 1'b1);
    send(1'b0, 1'b0, 3'd1, 16'd99, 16'd0, 1'b0);
    send(1'b0, 1'b0, 3'd1, 16'd99, 16'd0, 1'b0);
    send(1'b1, 1'b0, 3'd0, 16'd9, 16'd9, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'd16, 1'b0);

    // Frame restart with order 0.
    send(1'b1, 1'b1, 3'd0, 16'd7, 16'd7, 1'b0);

    // Order 7 behaves as order 4, including a mid-subframe abort.
    send(1'b1, 1'b1, 3'd7, 16'd50, 16'd50, 1'b1);
    send(1'b1, 1'b1, 3'd7, 16'd1, 16'd1, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd2, 16'd2, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd3, 16'd3, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd4, 16'd4, 1'b1);
    send(1'b1, 1'b0, 3'd0, 16'd0, 16'd5, 1'b0);

    // Roundtrip with a reset in the middle of the stream.
    roundtrip(3'd4, 5000);
    do_reset(1);
    send(1'b1, 1'b0, 3'd4, 16'h0ABC, 16'h0ABC, 1'b0);
    roundtrip(3'd5, 5000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
